fetch_stage: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined core.
- Holds the PC and drives the instruction-memory address. Captures the fetched instruction into an IF/ID pipeline register.
- Resolves control transfers requested by decode: jmp, taken branch (PC-relative), call, ret.
- Keeps a circular return-address stack (RAS) of configurable depth, with stall, flush and sticky RAS error flags.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and decode redirects (jmp/branch/call/ret).
// Keeps a circular return-address stack with sticky overflow/underflow flags. Optional FETCH_PERF_CNT_EN adds bubble/redirect counters.
module fetch_stage #(
  parameter int              PC_W      = 12,
  parameter int              INST_W    = 14,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              dec_jmp,
  input  logic              dec_branch,
  input  logic              dec_call,
  input  logic              dec_ret,
  input  logic [PC_W-1:0]   dec_target,
  input  logic [OFF_W-1:0]  dec_offset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [PC_W-1:0]   if_id_pc1,
  output logic              if_id_valid,
  output logic              ras_ovf,
  output logic              ras_unf
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       redirect_cnt
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  redirect_pc;
  logic [PTR_W-1:0] ras_tp;
  logic [CNT_W-1:0] ras_cnt;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic             qual;
  logic             do_ret;
  logic             do_call;
  logic             do_jmp;
  logic             do_br;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;

  assign imem_addr = pc;
  assign pc_inc    = pc + PC_W'(1);
  assign br_target = if_id_pc1 + {{(PC_W-OFF_W){dec_offset[OFF_W-1]}}, dec_offset};
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_FULL);

  // Only one request wins per cycle, so at most one RAS operation happens.
  assign qual     = if_id_valid & ~stall & ~flush;
  assign do_ret   = qual & dec_ret;
  assign do_call  = qual & dec_call & ~dec_ret;
  assign do_jmp   = qual & dec_jmp & ~dec_call & ~dec_ret;
  assign do_br    = qual & dec_branch & ~dec_jmp & ~dec_call & ~dec_ret;
  assign redirect = do_ret | do_call | do_jmp | do_br;

  always_comb begin
    redirect_pc = pc_inc;
    if (do_ret)
      redirect_pc = ras_empty ? RESET_PC : ras_mem[ras_tp];
    else if (do_call || do_jmp)
      redirect_pc = dec_target;
    else if (do_br)
      redirect_pc = br_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      if_id_inst  <= '0;
      if_id_pc    <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      pc          <= flush_pc;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
    end else if (redirect) begin
      // Squash the wrong-path fetch: one-cycle bubble.
      pc          <= redirect_pc;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_inc;
      if_id_inst  <= imem_data;
      if_id_pc    <= pc;
      if_id_pc1   <= pc_inc;
      if_id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_tp  <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (do_call) begin
      ras_tp <= ras_tp + PTR_W'(1);
      if (ras_full)
        ras_ovf <= 1'b1;
      else
        ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (do_ret) begin
      if (ras_empty) begin
        ras_unf <= 1'b1;
      end else begin
        ras_tp  <= ras_tp - PTR_W'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; entries are only read while ras_cnt says they are live.
  always_ff @(posedge clk) begin
    if (do_call)
      ras_mem[ras_tp + PTR_W'(1)] <= if_id_pc1;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if ((flush || (!stall && redirect)) && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
      if (redirect && redirect_cnt != 16'hFFFF)
        redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default parameters, imem_data = address).
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [11:0] flush_pc;
  logic        dec_jmp, dec_branch, dec_call, dec_ret;
  logic [11:0] dec_target;
  logic [7:0]  dec_offset;
  logic [11:0] imem_addr;
  logic [13:0] imem_data;
  logic [13:0] if_id_inst;
  logic [11:0] if_id_pc, if_id_pc1;
  logic        if_id_valid, ras_ovf, ras_unf;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_cnt, redirect_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign imem_data = {2'b00, imem_addr};

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .dec_jmp(dec_jmp), .dec_branch(dec_branch), .dec_call(dec_call), .dec_ret(dec_ret),
    .dec_target(dec_target), .dec_offset(dec_offset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc1(if_id_pc1),
    .if_id_valid(if_id_valid), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
`ifdef FETCH_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    dec_jmp = 0; dec_branch = 0; dec_call = 0; dec_ret = 0;
  endtask

  // Call with a live IF/ID: redirect edge, then the target enters IF/ID.
  task automatic do_call_to(input logic [11:0] tgt, input string tag);
    dec_call = 1; dec_target = tgt;
    step();
    chk({tag, "_pc"}, imem_addr, tgt);
    chk({tag, "_bubble"}, if_id_valid, 1'b0);
    clr_dec();
    step();
    chk({tag, "_ifid"}, if_id_pc, tgt);
  endtask

  task automatic do_ret_to(input logic [11:0] exp_pc, input string tag);
    dec_ret = 1;
    step();
    chk({tag, "_pc"}, imem_addr, exp_pc);
    chk({tag, "_bubble"}, if_id_valid, 1'b0);
    clr_dec();
    step();
    chk({tag, "_ifid"}, if_id_pc, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; stall = 0; flush = 0; flush_pc = '0;
    clr_dec(); dec_target = '0; dec_offset = '0;
    #12;
    chk("rst_pc", imem_addr, 12'h000);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_ifid_pc1", if_id_pc1, 12'h000);
    chk("rst_flags", {ras_ovf, ras_unf}, 2'b00);
    #6 rst = 1;

    // Sequential fetch 0,1,2,3
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_ifid_pc", if_id_pc, i);
      chk("seq_ifid_inst", if_id_inst, i);
      chk("seq_pc1", if_id_pc1, i + 1);
      chk("seq_valid", if_id_valid, 1'b1);
    end
    step(); step();
    chk("pre_br_ifid", if_id_pc, 12'h005);

    // Branch back: 6 + (-4) = 2
    dec_branch = 1; dec_offset = 8'hFC;
    step();
    chk("br_pc", imem_addr, 12'h002);
    chk("br_bubble", if_id_valid, 1'b0);
    clr_dec();
    step();
    chk("br_ifid", if_id_pc, 12'h002);
    chk("br_valid", if_id_valid, 1'b1);
    step();
    chk("pre_call_ifid", if_id_pc, 12'h003);

    // Call 0x40 from 3 (push 4), ret back to 4
    do_call_to(12'h040, "call1");
    chk("call1_cnt", dut.ras_cnt, 1);
    do_ret_to(12'h004, "ret1");
    chk("ret1_cnt", dut.ras_cnt, 0);
    chk("ret1_flags", {ras_ovf, ras_unf}, 2'b00);

    // Nine nested calls from 4: pushes 5, 0x111 ... 0x181
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) chk("ovf_before_9", ras_ovf, 1'b0);
      do_call_to(12'h100 + 12'(16 * k), "ncall");
    end
    chk("ovf_after_9", ras_ovf, 1'b1);
    chk("cnt_full", dut.ras_cnt, 8);
    for (int k = 8; k >= 1; k--)
      do_ret_to(12'h101 + 12'(16 * k), "nret");
    chk("unf_before_9", ras_unf, 1'b0);
    do_ret_to(12'h000, "nret9");
    chk("unf_after_9", ras_unf, 1'b1);
    chk("ifid_pc_after_9", if_id_pc, 12'h000);

    // Stall 3 cycles with jmp pending, then flush to 0x100 (overrides stall)
    stall = 1; dec_jmp = 1; dec_target = 12'h055;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", imem_addr, 12'h001);
      chk("stall_ifid", if_id_pc, 12'h000);
      chk("stall_valid", if_id_valid, 1'b1);
    end
    flush = 1; flush_pc = 12'h100;
    step();
    chk("flush_pc", imem_addr, 12'h100);
    chk("flush_valid", if_id_valid, 1'b0);
    flush = 0; stall = 0; clr_dec();
    step();
    chk("flush_ifid", if_id_pc, 12'h100);

    // jmp beats branch; a request during the bubble is ignored
    dec_jmp = 1; dec_target = 12'h030; dec_branch = 1; dec_offset = 8'h10;
    step();
    chk("prio_jmp_pc", imem_addr, 12'h030);
    dec_branch = 0; dec_target = 12'h077;
    step();
    chk("unqual_pc", imem_addr, 12'h031);
    chk("unqual_ifid", if_id_pc, 12'h030);
    clr_dec();

    // ret beats call: stack empty, so ret goes to RESET_PC and nothing is pushed
    dec_ret = 1; dec_call = 1; dec_target = 12'h0AA;
    step();
    chk("prio_ret_pc", imem_addr, 12'h000);
    chk("prio_ret_cnt", dut.ras_cnt, 0);
    clr_dec();
    step();

    // PC wrap FFF -> 0
    flush = 1; flush_pc = 12'hFFF;
    step();
    flush = 0;
    step();
    chk("wrap_ifid_pc", if_id_pc, 12'hFFF);
    chk("wrap_pc1", if_id_pc1, 12'h000);
    chk("wrap_inst", if_id_inst, 14'h0FFF);
    chk("wrap_pc", imem_addr, 12'h000);

    // Reset mid-stream during a pending ret
    do_call_to(12'h020, "call_rst");
    dec_ret = 1;
    #3 rst = 0;
    #1;
    chk("midrst_pc", imem_addr, 12'h000);
    chk("midrst_valid", if_id_valid, 1'b0);
    chk("midrst_flags", {ras_ovf, ras_unf}, 2'b00);
    chk("midrst_cnt", dut.ras_cnt, 0);
    step();
    chk("midrst_hold_pc", imem_addr, 12'h000);
    clr_dec();
    #2 rst = 1;
    step();
    chk("post_rst_ifid", if_id_pc, 12'h000);
    chk("post_rst_valid", if_id_valid, 1'b1);
    do_ret_to(12'h000, "post_rst_ret");
    chk("post_rst_unf", ras_unf, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
